// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED step control slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package led_pkg;

    localparam int SPEED_W    = 2;
    localparam int NUM_SPEEDS = 4;
    localparam int DEF_CLK_HZ = 27_000_000;

    typedef logic [SPEED_W-1:0] speed_t;

    // Number of clocks a button level must stay stable before it is accepted.
    function automatic int db_cycles(input int clk_hz, input int debounce_ms);
        return (clk_hz / 1000) * debounce_ms;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces one active-low push-button, emits a press pulse.
// Latency: raw low first sampled at edge 1 -> level flips and press pulses at edge DB_CYCLES+2.
// Backpressure: none; press is a one-cycle strobe the consumer must take immediately.
module btn_debounce #(
    parameter int DB_CYCLES = 540_000,
    parameter int CNT_W     = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press
);

    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic [CNT_W-1:0] r_dcnt;
    logic             r_press;
    logic             w_dcnt_done;

    assign w_dcnt_done = (r_dcnt == CNT_W'(DB_CYCLES - 1));

    // Two-flop synchronizer, stability counter and registered press pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_db    <= 1'b1;
            r_dcnt  <= '0;
            r_press <= 1'b0;
        end else begin
            r_s1    <= btn_n;
            r_s2    <= r_s1;
            r_press <= 1'b0;
            if (r_s2 == r_db) begin
                r_dcnt <= '0;
            end else if (w_dcnt_done) begin
                r_db    <= r_s2;
                r_dcnt  <= '0;
                // Only the released->pressed transition is an event.
                r_press <= ~r_s2;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end

    assign level = r_db;
    assign press = r_press;

endmodule

// File: rtl/led_step_ctrl.sv
// Shared step-strobe source for LED effects: speed button cycles 4 rates, pause button toggles hold.
// Latency: button press updates speed/paused one edge after the debounced press pulse; step is registered.
// Backpressure: none; step is a one-cycle strobe, period BASE_DIV>>speed clocks while running.
module led_step_ctrl
    import led_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int DEBOUNCE_MS = 20,
    parameter int BASE_DIV    = 13_500_000,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_speed_n,
    input  logic               btn_pause_n,
    output logic               step,
    output logic [SPEED_W-1:0] speed,
    output logic               paused
);

    localparam int DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);

    logic             w_speed_lvl;
    logic             w_speed_evt;
    logic             w_pause_lvl;
    logic             w_pause_evt;
    logic             w_speed_press;
    logic             w_pause_press;
    logic             w_paused_nxt;
    logic [CNT_W-1:0] w_div;
    logic [CNT_W-1:0] w_div_last;

    logic [CNT_W-1:0] r_pcnt;
    logic             r_step;
    speed_t           r_speed;
    logic             r_paused;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_db_speed (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_speed_n),
        .level (w_speed_lvl),
        .press (w_speed_evt)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_db_pause (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_pause_n),
        .level (w_pause_lvl),
        .press (w_pause_evt)
    );

    // A press pulse always coincides with the debounced level being pressed;
    // qualifying on the level keeps a stray pulse from ever acting on a release.
    assign w_speed_press = w_speed_evt & ~w_speed_lvl;
    assign w_pause_press = w_pause_evt & ~w_pause_lvl;

    // Pause takes effect on the same edge it toggles, so the hold decision
    // uses the post-toggle value.
    assign w_paused_nxt = r_paused ^ w_pause_press;

    // Each speed level halves the step period.
    assign w_div      = CNT_W'(BASE_DIV) >> r_speed;
    assign w_div_last = w_div - 1'b1;

    // Speed/pause state and the prescaler that generates the step strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt   <= '0;
            r_step   <= 1'b0;
            r_speed  <= '0;
            r_paused <= 1'b0;
        end else begin
            r_paused <= w_paused_nxt;
            if (w_speed_press) begin
                r_speed <= r_speed + 1'b1;
            end
            // A speed change restarts the period and suppresses a coincident step.
            if (w_speed_press) begin
                r_pcnt <= '0;
                r_step <= 1'b0;
            end else if (w_paused_nxt) begin
                r_step <= 1'b0;
            end else if (r_pcnt == w_div_last) begin
                r_pcnt <= '0;
                r_step <= 1'b1;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
                r_step <= 1'b0;
            end
        end
    end

    assign step   = r_step;
    assign speed  = r_speed;
    assign paused = r_paused;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with CLK_HZ=1000, DEBOUNCE_MS=4, BASE_DIV=16.
// Edge numbers are counted from reset release (first edge after release = 1).
// Step pulses are timestamped by a monitor and compared against hand-computed lists.
module tb_led_step_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_speed_n = 1'b1;
    logic       btn_pause_n = 1'b1;
    logic       step;
    logic [1:0] speed;
    logic       paused;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int step_q[$];

    always #5 clk = ~clk;

    led_step_ctrl #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .BASE_DIV    (16),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_speed_n (btn_speed_n),
        .btn_pause_n (btn_pause_n),
        .step        (step),
        .speed       (speed),
        .paused      (paused)
    );

    // Edge counter since reset release and step timestamp recorder.
    always @(posedge clk) begin
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
        #1;
        if (step === 1'b1) step_q.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 5000) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_speed_n = 1'b1;
        btn_pause_n = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        step_q.delete();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (step !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", step); end
        checks++; if (speed !== 2'd0) begin failures++; $display("FAIL reset_speed got=%0d exp=0", speed); end
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL reset_paused got=%b exp=0", paused); end
    endtask

    task automatic test_free_run();
        int exp_q[$];
        do_reset();
        exp_q = '{16, 32, 48};
        run_to(50);
        checks++; if (step_q.size() != exp_q.size()) begin failures++; $display("FAIL free_run_count got=%0d exp=%0d", step_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < step_q.size()) begin
            checks++; if (step_q[i] != exp_q[i]) begin failures++; $display("FAIL free_run_step[%0d] got=%0d exp=%0d", i, step_q[i], exp_q[i]); end
        end
        checks++; if (speed !== 2'd0 || paused !== 1'b0) begin failures++; $display("FAIL free_run_state got=%0d/%b exp=0/0", speed, paused); end
    endtask

    // Four presses 25 edges apart; each lands speed one edge after the debounced pulse.
    task automatic test_speed();
        int exp_q[$];
        int s;
        logic [1:0] want;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            s = 25 * k;
            run_to(s);
            btn_speed_n = 1'b0;
            run_to(s + 6);
            want = 2'(k);
            checks++; if (speed !== want) begin failures++; $display("FAIL speed_before[%0d] got=%0d exp=%0d", k, speed, want); end
            run_to(s + 7);
            want = 2'(k + 1);
            checks++; if (speed !== want) begin failures++; $display("FAIL speed_after[%0d] got=%0d exp=%0d", k, speed, want); end
            run_to(s + 10);
            btn_speed_n = 1'b1;
        end
        run_to(120);
        exp_q = '{15, 23, 31, 36, 40, 44, 48, 52, 56,
                  59, 61, 63, 65, 67, 69, 71, 73, 75, 77, 79, 81, 98, 114};
        checks++; if (step_q.size() != exp_q.size()) begin failures++; $display("FAIL speed_step_count got=%0d exp=%0d", step_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < step_q.size()) begin
            checks++; if (step_q[i] != exp_q[i]) begin failures++; $display("FAIL speed_step[%0d] got=%0d exp=%0d", i, step_q[i], exp_q[i]); end
        end
    endtask

    // Short pulse and a 2-clock bounce train must not qualify as a press.
    task automatic test_glitch();
        int exp_q[$];
        do_reset();
        btn_speed_n = 1'b0;
        run_to(3);  btn_speed_n = 1'b1;
        run_to(10); btn_speed_n = 1'b0;
        run_to(12); btn_speed_n = 1'b1;
        run_to(14); btn_speed_n = 1'b0;
        run_to(16); btn_speed_n = 1'b1;
        run_to(40);
        checks++; if (speed !== 2'd0) begin failures++; $display("FAIL glitch_speed got=%0d exp=0", speed); end
        exp_q = '{16, 32};
        checks++; if (step_q.size() != exp_q.size()) begin failures++; $display("FAIL glitch_step_count got=%0d exp=%0d", step_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < step_q.size()) begin
            checks++; if (step_q[i] != exp_q[i]) begin failures++; $display("FAIL glitch_step[%0d] got=%0d exp=%0d", i, step_q[i], exp_q[i]); end
        end
    endtask

    // Pause lands at edge 22 with pcnt=5; unpause at 132 resumes from 5, step at 132+10.
    task automatic test_pause();
        int exp_q[$];
        do_reset();
        run_to(15); btn_pause_n = 1'b0;
        run_to(21);
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL pause_before got=%b exp=0", paused); end
        run_to(22);
        checks++; if (paused !== 1'b1) begin failures++; $display("FAIL pause_on got=%b exp=1", paused); end
        run_to(25); btn_pause_n = 1'b1;
        run_to(125);
        checks++; if (paused !== 1'b1) begin failures++; $display("FAIL pause_held got=%b exp=1", paused); end
        btn_pause_n = 1'b0;
        run_to(131);
        checks++; if (paused !== 1'b1) begin failures++; $display("FAIL unpause_before got=%b exp=1", paused); end
        run_to(132);
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL unpause got=%b exp=0", paused); end
        run_to(135); btn_pause_n = 1'b1;
        run_to(160);
        exp_q = '{16, 142, 158};
        checks++; if (step_q.size() != exp_q.size()) begin failures++; $display("FAIL pause_step_count got=%0d exp=%0d", step_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < step_q.size()) begin
            checks++; if (step_q[i] != exp_q[i]) begin failures++; $display("FAIL pause_step[%0d] got=%0d exp=%0d", i, step_q[i], exp_q[i]); end
        end
    endtask

    // Speed and pause pulses both land on edge 32, where pcnt is at its terminal count.
    task automatic test_coincident();
        int exp_q[$];
        do_reset();
        run_to(25);
        btn_speed_n = 1'b0;
        btn_pause_n = 1'b0;
        run_to(31);
        checks++; if (speed !== 2'd0 || paused !== 1'b0) begin failures++; $display("FAIL coinc_before got=%0d/%b exp=0/0", speed, paused); end
        run_to(32);
        checks++; if (step !== 1'b0) begin failures++; $display("FAIL coinc_step got=%b exp=0", step); end
        checks++; if (speed !== 2'd1) begin failures++; $display("FAIL coinc_speed got=%0d exp=1", speed); end
        checks++; if (paused !== 1'b1) begin failures++; $display("FAIL coinc_paused got=%b exp=1", paused); end
        run_to(35);
        btn_speed_n = 1'b1;
        btn_pause_n = 1'b1;
        run_to(60); btn_pause_n = 1'b0;
        run_to(67);
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL coinc_unpause got=%b exp=0", paused); end
        run_to(70); btn_pause_n = 1'b1;
        run_to(85);
        exp_q = '{16, 74, 82};
        checks++; if (step_q.size() != exp_q.size()) begin failures++; $display("FAIL coinc_step_count got=%0d exp=%0d", step_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < step_q.size()) begin
            checks++; if (step_q[i] != exp_q[i]) begin failures++; $display("FAIL coinc_step[%0d] got=%0d exp=%0d", i, step_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        // Outputs drop between edges when reset is asserted.
        btn_speed_n = 1'b0;
        run_to(10); btn_speed_n = 1'b1;
        run_to(23);
        checks++; if (step !== 1'b1 || speed !== 2'd1) begin failures++; $display("FAIL pre_rst got=%b/%0d exp=1/1", step, speed); end
        #3; rst = 1'b1; #1;
        checks++; if (step !== 1'b0) begin failures++; $display("FAIL async_rst_step got=%b exp=0", step); end
        checks++; if (speed !== 2'd0) begin failures++; $display("FAIL async_rst_speed got=%0d exp=0", speed); end
        tick();
        rst = 1'b0;
        step_q.delete();
        // First step after release comes a full base period later.
        run_to(20);
        checks++; if (step_q.size() != 1) begin failures++; $display("FAIL post_rst_count got=%0d exp=1", step_q.size()); end
        if (step_q.size() > 0) begin
            checks++; if (step_q[0] != 16) begin failures++; $display("FAIL post_rst_first got=%0d exp=16", step_q[0]); end
        end
        btn_pause_n = 1'b0;
        run_to(27);
        checks++; if (paused !== 1'b1) begin failures++; $display("FAIL pre_rst_paused got=%b exp=1", paused); end
        run_to(30); btn_pause_n = 1'b1;
        #3; rst = 1'b1; #1;
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL async_rst_paused got=%b exp=0", paused); end
        // Button held down across reset release: reset restores the released
        // level, so the held button qualifies once and never repeats while held.
        btn_speed_n = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        run_to(6);
        checks++; if (speed !== 2'd0) begin failures++; $display("FAIL held_early got=%0d exp=0", speed); end
        run_to(40);
        checks++; if (speed !== 2'd1) begin failures++; $display("FAIL held_once got=%0d exp=1", speed); end
        btn_speed_n = 1'b1;
        run_to(55);
        checks++; if (speed !== 2'd1) begin failures++; $display("FAIL release_no_evt got=%0d exp=1", speed); end
        btn_speed_n = 1'b0;
        run_to(62);
        checks++; if (speed !== 2'd2) begin failures++; $display("FAIL repress got=%0d exp=2", speed); end
        run_to(65); btn_speed_n = 1'b1;
        run_to(80);
        checks++; if (speed !== 2'd2) begin failures++; $display("FAIL repress_final got=%0d exp=2", speed); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_speed();
        test_glitch();
        test_pause();
        test_coincident();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
